adc_channel_scheduler: RTL

Round-robin command sequencer that shares the MAX10 modular ADC between up to NUM_SLOTS sensor slots (e.g. pedal, battery, motor current). It sits between the `adc_qsys` Avalon-ST command/response ports and the dashboard logic. It issues one conversion command at a time, then matches the response channel against the issued channel. Each accepted sample is stored in a per-slot register and flagged with a one-cycle update strobe.

---
 rtl/adc_channel_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/adc_channel_scheduler.sv
// adc_channel_scheduler: round-robin command sequencer sharing one ADC between NUM_SLOTS sensor slots
//
// Optional feature macro: ADC_RSP_TIMEOUT_EN (response timeout counter in WAIT).
//
// Ports:
//   sys_clk, reset_n            clock, synchronous active-low reset
//   slot_en[NUM_SLOTS]          per-slot request enable
//   chan_map[5*NUM_SLOTS]       ADC channel per slot, slot i at [5i+4:5i]
//   err_clr                     clears the sticky error flags
//   cmd_valid/channel/sop/eop   Avalon-ST command to the ADC, cmd_ready back
//   rsp_valid/channel/data      Avalon-ST response from the ADC
//   sample_data[12*NUM_SLOTS]   latest sample per slot
//   sample_upd[NUM_SLOTS]       one-cycle strobe on the updated slot
//   busy                        a command is being issued or awaited
//   err_mismatch, err_timeout   sticky error flags
module adc_channel_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic [NUM_SLOTS-1:0]    slot_en,
    input  logic [5*NUM_SLOTS-1:0]  chan_map,
    input  logic                    err_clr,
    output logic                    cmd_valid,
    output logic [4:0]              cmd_channel,
    output logic                    cmd_sop,
    output logic                    cmd_eop,
    input  logic                    cmd_ready,
    input  logic                    rsp_valid,
    input  logic [4:0]              rsp_channel,
    input  logic [11:0]             rsp_data,
    output logic [12*NUM_SLOTS-1:0] sample_data,
    output logic [NUM_SLOTS-1:0]    sample_upd,
    output logic                    busy,
    output logic                    err_mismatch,
    output logic                    err_timeout
);
    localparam int SW = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] cur_slot;
    logic [SW-1:0] pick;
    logic [4:0]    cur_ch;
    logic          found;
    int            idx;

    assign cmd_sop     = 1'b1;
    assign cmd_eop     = 1'b1;
    assign cmd_channel = cur_ch;

    // Walk from the farthest candidate to the nearest so the slot closest
    // after rr_ptr is the one left in pick.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_SLOTS;
            if (slot_en[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

`ifdef ADC_RSP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign err_timeout    = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= SW'(NUM_SLOTS - 1);
            cur_slot     <= '0;
            cur_ch       <= '0;
            cmd_valid    <= 1'b0;
            sample_data  <= '0;
            sample_upd   <= '0;
            busy         <= 1'b0;
            err_mismatch <= 1'b0;
`ifdef ADC_RSP_TIMEOUT_EN
            err_timeout  <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            sample_upd <= '0;
            // Clear first so a simultaneous error event below takes priority.
            if (err_clr) begin
                err_mismatch <= 1'b0;
`ifdef ADC_RSP_TIMEOUT_EN
                err_timeout  <= 1'b0;
`endif
            end
            if (rsp_valid && state != WAIT) err_mismatch <= 1'b1;
            case (state)
                IDLE: if (found) begin
                    cur_slot  <= pick;
                    cur_ch    <= chan_map[5*pick +: 5];
                    rr_ptr    <= pick;
                    cmd_valid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= WAIT;
`ifdef ADC_RSP_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT: if (rsp_valid) begin
                    if (rsp_channel == cur_ch) begin
                        sample_data[12*cur_slot +: 12] <= rsp_data;
                        sample_upd[cur_slot]           <= 1'b1;
                    end else begin
                        err_mismatch <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`ifdef ADC_RSP_TIMEOUT_EN
                else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
